pos_aim: RTL and testbench
==========================

POS_AIM -- requirements
Module: pos_aim

Interface
REQ-001: clk  input  1  system clock; all state updates on rising edge.
REQ-002: reset  input  1  synchronous, active-high reset.
REQ-003: left_x  input  1  move-left button, level, synchronous to clk.
REQ-004: right_x  input  1  move-right button, level, synchronous to clk.
REQ-005: left_aim  input  1  rotate-aim-left button, level, synchronous to clk.
REQ-006: right_aim  input  1  rotate-aim-right button, level, synchronous to clk.
REQ-007: x_pos  output  5  horizontal position, unsigned, 0 (leftmost) to 31 (rightmost).
REQ-008: run  output  5  horizontal magnitude of aim vector, unsigned.
REQ-009: rise  output  5  vertical magnitude of aim vector, unsigned.
REQ-010: dir  output  1  aim horizontal direction; 0 = left or vertical, 1 = right.

Function
REQ-011: The block SHALL keep one registered previous-sample bit per button, updated every cycle, including during reset.
REQ-012: A button press event SHALL be button high while its previous sample is low; one event per press; holding a button produces no further events.
REQ-013: A left_x event SHALL decrement x_pos by 1, saturating at 0.
REQ-014: A right_x event SHALL increment x_pos by 1, saturating at 31.
REQ-015: Simultaneous left_x and right_x events in the same cycle SHALL leave x_pos unchanged.
REQ-016: The block SHALL hold an internal aim index A, 4 bits, range 0..14; 7 = straight up, below 7 = tilted left, above 7 = tilted right.
REQ-017: A left_aim event SHALL decrement A by 1, saturating at 0; a right_aim event SHALL increment A by 1, saturating at 14.
REQ-018: Simultaneous left_aim and right_aim events SHALL leave A unchanged.
REQ-019: Position and aim logic SHALL be independent; x and aim events in the same cycle SHALL both take effect.
REQ-020: With magnitude M = |A - 7| (0..7): run SHALL equal 4*M and rise SHALL equal 28 - 4*M; run + rise = 28 always.
REQ-021: dir SHALL be 1 when A > 7 and 0 when A <= 7.
REQ-022: x_pos, run, rise and dir SHALL be registered, or combinational from registered state only; an event sampled at edge N is visible on outputs right after edge N (1-cycle latency from input rise).
REQ-023: Outputs SHALL never leave their ranges: x_pos 0..31, run and rise 0..28, multiples of 4.

Reset
REQ-024: While reset is high at a rising clk edge: x_pos = 16, A = 7, so run = 0, rise = 28, dir = 0.
REQ-025: Reset SHALL override all button events in the same cycle.
REQ-026: During reset the previous-sample bits SHALL capture the current button levels, so a button held through reset release generates no event until released and pressed again.
REQ-027: Reset asserted mid-operation SHALL restore the REQ-024 values on the next edge regardless of prior state.

Verification
REQ-028: Reset 2 cycles, all buttons low -> x_pos=16, run=0, rise=28, dir=0.
REQ-029: 3 separate right_x pulses (1 cycle high, 1 low) -> x_pos=19; hold right_x high 10 cycles -> x_pos=20 only.
REQ-030: 20 left_x pulses from x_pos=16 -> x_pos=0 and stays 0; 40 right_x pulses -> x_pos=31 and stays 31.
REQ-031: From reset, 2 right_aim pulses -> run=8, rise=20, dir=1; then 5 left_aim pulses -> run=12, rise=16, dir=0; 10 more left_aim pulses -> run=28, rise=0, dir=0 (saturated).
REQ-032: left_x and right_x rise in the same cycle -> x_pos unchanged; left_aim and right_x rise together -> A and x_pos both step.
REQ-033: right_x held high across reset release -> x_pos stays 16 until right_x goes low and high again, then 17; reset asserted with x_pos=25, A=12 -> next edge x_pos=16, run=0, rise=28, dir=0.

Source files
------------

// File: rtl/pos_aim.sv
// Cursor position and aim-angle controller driven by four edge-detected buttons.
// Position saturates at 0..31; aim index 0..14 maps to a run/rise vector summing to 28.
module pos_aim (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_x,
  input  logic       right_x,
  input  logic       left_aim,
  input  logic       right_aim,
  output logic [4:0] x_pos,
  output logic [4:0] run,
  output logic [4:0] rise,
  output logic       dir
);

  localparam int unsigned X_W      = 5;
  localparam int unsigned AIM_W    = 4;
  localparam int unsigned X_MAX    = 31;
  localparam int unsigned X_RST    = 16;
  localparam int unsigned AIM_MAX  = 14;
  localparam int unsigned AIM_UP   = 7;
  localparam int unsigned RISE_MAX = 28;

  logic             prev_left_x;
  logic             prev_right_x;
  logic             prev_left_aim;
  logic             prev_right_aim;
  logic             ev_left_x;
  logic             ev_right_x;
  logic             ev_left_aim;
  logic             ev_right_aim;
  logic [AIM_W-1:0] aim;
  logic [AIM_W-1:0] aim_next;
  logic [X_W-1:0]   x_next;
  logic [AIM_W-1:0] aim_diff;
  logic [X_W-1:0]   run_next;
  logic [X_W-1:0]   rise_next;
  logic             dir_next;

  // Previous samples track the buttons every cycle, reset included, so a
  // button held through reset release does not register as a new press.
  always_ff @(posedge clk) begin
    prev_left_x    <= left_x;
    prev_right_x   <= right_x;
    prev_left_aim  <= left_aim;
    prev_right_aim <= right_aim;
  end

  assign ev_left_x    = left_x    & ~prev_left_x;
  assign ev_right_x   = right_x   & ~prev_right_x;
  assign ev_left_aim  = left_aim  & ~prev_left_aim;
  assign ev_right_aim = right_aim & ~prev_right_aim;

  // Next position and aim; opposing events in the same cycle cancel.
  always_comb begin
    x_next   = x_pos;
    aim_next = aim;
    if (ev_left_x && !ev_right_x && x_pos != X_W'(0)) begin
      x_next = x_pos - X_W'(1);
    end else if (ev_right_x && !ev_left_x && x_pos != X_W'(X_MAX)) begin
      x_next = x_pos + X_W'(1);
    end
    if (ev_left_aim && !ev_right_aim && aim != AIM_W'(0)) begin
      aim_next = aim - AIM_W'(1);
    end else if (ev_right_aim && !ev_left_aim && aim != AIM_W'(AIM_MAX)) begin
      aim_next = aim + AIM_W'(1);
    end
  end

  // Aim vector derived from the next aim index so it lands with the same edge.
  always_comb begin
    dir_next  = 1'b0;
    aim_diff  = AIM_W'(AIM_UP) - aim_next;
    if (aim_next > AIM_W'(AIM_UP)) begin
      dir_next = 1'b1;
      aim_diff = aim_next - AIM_W'(AIM_UP);
    end
    run_next  = {aim_diff[2:0], 2'b00};
    rise_next = X_W'(RISE_MAX) - run_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_pos <= X_W'(X_RST);
      aim   <= AIM_W'(AIM_UP);
      run   <= X_W'(0);
      rise  <= X_W'(RISE_MAX);
      dir   <= 1'b0;
    end else begin
      x_pos <= x_next;
      aim   <= aim_next;
      run   <= run_next;
      rise  <= rise_next;
      dir   <= dir_next;
    end
  end

endmodule

// File: tb/tb_pos_aim.sv
// Directed and random stimulus for pos_aim against an integer reference model.
module tb_pos_aim;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       left_x = 1'b0;
  logic       right_x = 1'b0;
  logic       left_aim = 1'b0;
  logic       right_aim = 1'b0;
  logic [4:0] x_pos;
  logic [4:0] run;
  logic [4:0] rise;
  logic       dir;

  int total = 0;
  int bad = 0;

  // Reference model state: plain integers plus last-seen button levels.
  int m_x = 16;
  int m_a = 7;
  bit p_lx = 0, p_rx = 0, p_la = 0, p_ra = 0;

  pos_aim dut (
    .clk       (clk),
    .reset     (reset),
    .left_x    (left_x),
    .right_x   (right_x),
    .left_aim  (left_aim),
    .right_aim (right_aim),
    .x_pos     (x_pos),
    .run       (run),
    .rise      (rise),
    .dir       (dir)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // One clock: drive buttons, advance the model, compare every output.
  task automatic step(input bit lx, input bit rx, input bit la, input bit ra, input bit rst);
    int mag;
    left_x = lx; right_x = rx; left_aim = la; right_aim = ra; reset = rst;
    @(posedge clk);
    if (rst) begin
      m_x = 16;
      m_a = 7;
    end else begin
      m_x = clamp(m_x + int'(rx && !p_rx) - int'(lx && !p_lx), 0, 31);
      m_a = clamp(m_a + int'(ra && !p_ra) - int'(la && !p_la), 0, 14);
    end
    p_lx = lx; p_rx = rx; p_la = la; p_ra = ra;
    #1;
    mag = (m_a > 7) ? m_a - 7 : 7 - m_a;
    check("x_pos", int'(x_pos), m_x);
    check("run",   int'(run),   4 * mag);
    check("rise",  int'(rise),  28 - 4 * mag);
    check("dir",   int'(dir),   int'(m_a > 7));
  endtask

  task automatic pulse(input bit lx, input bit rx, input bit la, input bit ra, input int n);
    for (int i = 0; i < n; i++) begin
      step(lx, rx, la, ra, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_out(input string tag, input int ex, input int er, input int ei, input int ed);
    check({tag, "_x"},    int'(x_pos), ex);
    check({tag, "_run"},  int'(run),   er);
    check({tag, "_rise"}, int'(rise),  ei);
    check({tag, "_dir"},  int'(dir),   ed);
  endtask

  initial begin
    do_reset();
    expect_out("reset", 16, 0, 28, 0);

    pulse(1'b0, 1'b1, 1'b0, 1'b0, 3);
    check("right3", int'(x_pos), 19);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("hold_right", int'(x_pos), 20);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    do_reset();
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 20);
    check("sat_left", int'(x_pos), 0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 40);
    check("sat_right", int'(x_pos), 31);

    do_reset();
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 2);
    expect_out("aim_r2", 16, 8, 20, 1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 5);
    expect_out("aim_l5", 16, 12, 16, 0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 10);
    expect_out("aim_sat", 16, 28, 0, 0);

    do_reset();
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 1);
    check("lr_cancel", int'(x_pos), 16);
    pulse(1'b0, 1'b1, 1'b1, 1'b0, 1);
    expect_out("x_and_aim", 17, 4, 24, 0);

    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("held_thru_rst", int'(x_pos), 16);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("repress", int'(x_pos), 17);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    do_reset();
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 9);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 5);
    expect_out("pre_rst", 25, 20, 8, 1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_out("mid_rst", 16, 0, 28, 0);

    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 99) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
